// File: rtl/cache_wb_if.sv
// Handshake bundle between cache_wb and its CPU/memory environment.
// The wide tri-state data buses stay as plain inout ports on cache_wb.
interface cache_wb_if #(
    parameter int WORD_SIZE = 16
) ();
    logic                 readC;
    logic                 writeC;
    logic [WORD_SIZE-1:0] address;
    logic                 readyC;
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] addressM;
    logic                 input_readyM;
    logic                 doneM;
    logic [WORD_SIZE-1:0] num_access;
    logic [WORD_SIZE-1:0] num_miss;
    logic [WORD_SIZE-1:0] num_writeback;

    modport master (
        output readC, writeC, address, input_readyM, doneM,
        input  readyC, readM, writeM, addressM, num_access, num_miss, num_writeback
    );

    modport slave (
        input  readC, writeC, address, input_readyM, doneM,
        output readyC, readM, writeM, addressM, num_access, num_miss, num_writeback
    );
endinterface

// File: rtl/cache_wb.sv
// Direct-mapped write-back, write-allocate cache with parametrised line count
// and block size; dirty victims are written back whole before the refill.
module cache_wb #(
    parameter int WORD_SIZE   = 16,
    parameter int LINES       = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    cache_wb_if.slave                          bus,
    inout  wire  [WORD_SIZE-1:0]               data,
    inout  wire  [BLOCK_WORDS*WORD_SIZE-1:0]   dataM
);
    localparam int OFF_BITS   = $clog2(BLOCK_WORDS);
    localparam int IDX_BITS   = $clog2(LINES);
    localparam int TAG_BITS   = WORD_SIZE - IDX_BITS - OFF_BITS;
    localparam int BLOCK_SIZE = BLOCK_WORDS * WORD_SIZE;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE  = 2'd2;

    localparam logic [WORD_SIZE-1:0] CNT_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [BLOCK_SIZE-1:0] data_bank_q [LINES];
    logic [BLOCK_SIZE-1:0] data_bank_d [LINES];
    logic [TAG_BITS-1:0]   tag_bank_q  [LINES];
    logic [TAG_BITS-1:0]   tag_bank_d  [LINES];
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic [WORD_SIZE-1:0]  num_access_q, num_access_d;
    logic [WORD_SIZE-1:0]  num_miss_q, num_miss_d;
    logic [WORD_SIZE-1:0]  num_writeback_q, num_writeback_d;

    logic [TAG_BITS-1:0]   tag_s;
    logic [IDX_BITS-1:0]   idx_s;
    logic [OFF_BITS-1:0]   off_s;
    logic                  req_s;
    logic                  hit_s;
    logic                  ready_s;
    logic                  drive_cpu_s;
    logic [WORD_SIZE-1:0]  rd_word_s;
    logic [WORD_SIZE-1:0]  address_m_s;
    logic [BLOCK_SIZE-1:0] victim_s;

    assign tag_s       = bus.address[WORD_SIZE-1 -: TAG_BITS];
    assign idx_s       = bus.address[OFF_BITS +: IDX_BITS];
    assign off_s       = bus.address[OFF_BITS-1:0];
    assign req_s       = bus.readC || bus.writeC;
    assign hit_s       = valid_q[idx_s] && (tag_bank_q[idx_s] == tag_s);
    assign ready_s     = (state_q == ST_IDLE) && req_s && hit_s;
    // A simultaneous readC/writeC is a write, so the CPU owns the bus then.
    assign drive_cpu_s = bus.readC && !bus.writeC && ready_s;
    assign rd_word_s   = data_bank_q[idx_s][off_s*WORD_SIZE +: WORD_SIZE];
    assign victim_s    = data_bank_q[idx_s];

    assign bus.readyC        = ready_s;
    assign bus.readM         = (state_q == ST_ALLOCATE);
    assign bus.writeM        = (state_q == ST_WRITEBACK);
    assign bus.addressM      = address_m_s;
    assign bus.num_access    = num_access_q;
    assign bus.num_miss      = num_miss_q;
    assign bus.num_writeback = num_writeback_q;

    assign data  = drive_cpu_s ? rd_word_s : {WORD_SIZE{1'bz}};
    assign dataM = (state_q == ST_WRITEBACK) ? victim_s : {BLOCK_SIZE{1'bz}};

    // Block-aligned memory address: victim tag during write-back, request tag during refill
    always_comb begin
        address_m_s = {WORD_SIZE{1'b0}};
        case (state_q)
            ST_WRITEBACK: address_m_s = {tag_bank_q[idx_s], idx_s, {OFF_BITS{1'b0}}};
            ST_ALLOCATE:  address_m_s = {tag_s, idx_s, {OFF_BITS{1'b0}}};
            default:      address_m_s = {WORD_SIZE{1'b0}};
        endcase
    end

    // Controller next state, line updates and statistics counters
    always_comb begin
        state_d         = state_q;
        data_bank_d     = data_bank_q;
        tag_bank_d      = tag_bank_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        num_miss_d      = num_miss_q;
        num_writeback_d = num_writeback_q;
        num_access_d    = ready_s ? (num_access_q + CNT_ONE) : num_access_q;

        case (state_q)
            ST_IDLE: begin
                if (ready_s && bus.writeC) begin
                    data_bank_d[idx_s][off_s*WORD_SIZE +: WORD_SIZE] = data;
                    dirty_d[idx_s] = 1'b1;
                end else if (req_s && !hit_s) begin
                    num_miss_d = num_miss_q + CNT_ONE;
                    state_d    = (valid_q[idx_s] && dirty_q[idx_s]) ? ST_WRITEBACK : ST_ALLOCATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (bus.doneM) begin
                    dirty_d[idx_s]  = 1'b0;
                    num_writeback_d = num_writeback_q + CNT_ONE;
                    state_d         = ST_ALLOCATE;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (bus.input_readyM) begin
                    data_bank_d[idx_s] = dataM;
                    tag_bank_d[idx_s]  = tag_s;
                    valid_d[idx_s]     = 1'b1;
                    dirty_d[idx_s]     = 1'b0;
                    state_d            = ST_IDLE;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset clears every line so an abandoned transfer leaves nothing behind
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            valid_q         <= {LINES{1'b0}};
            dirty_q         <= {LINES{1'b0}};
            num_access_q    <= {WORD_SIZE{1'b0}};
            num_miss_q      <= {WORD_SIZE{1'b0}};
            num_writeback_q <= {WORD_SIZE{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                data_bank_q[i] <= {BLOCK_SIZE{1'b0}};
                tag_bank_q[i]  <= {TAG_BITS{1'b0}};
            end
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            num_access_q    <= num_access_d;
            num_miss_q      <= num_miss_d;
            num_writeback_q <= num_writeback_d;
            for (int i = 0; i < LINES; i++) begin
                data_bank_q[i] <= data_bank_d[i];
                tag_bank_q[i]  <= tag_bank_d[i];
            end
        end
    end
endmodule

// File: tb/tb_cache_wb.sv
// Self-checking bench for cache_wb: table of CPU requests against a block
// memory model that answers refills and write-backs two cycles after the request.
module tb_cache_wb;
    logic clk;
    logic reset_n;

    cache_wb_if #(.WORD_SIZE(16)) bus ();

    logic        cpu_drv;
    logic [15:0] cpu_wdata;
    logic        mem_drv;
    logic [63:0] mem_wdata;
    wire  [15:0] data_w;
    wire  [63:0] dataM_w;

    assign data_w  = cpu_drv ? cpu_wdata : 16'hzzzz;
    assign dataM_w = mem_drv ? mem_wdata : {64{1'bz}};

    cache_wb #(.WORD_SIZE(16), .LINES(4), .BLOCK_WORDS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .data    (data_w),
        .dataM   (dataM_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        int          lat;
        logic [15:0] wb_addr;
        logic        chk_wbd;
        logic [63:0] wb_data;
    } vec_t;

    typedef struct {
        logic        is_read;
        logic [15:0] rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_access, exp_miss, exp_wb;

    // memory model state (written only by the responder process)
    logic [63:0] mem [16384];
    int          n_fill = 0, n_wb_seen = 0, overlap_err = 0, stab_err = 0;
    logic [15:0] last_fill_addr, last_wb_addr, prev_addr;
    logic [63:0] last_wb_data;
    int          rd_cnt, wr_cnt;
    int          stray_req = 0, stray_done = 0;
    logic        resp_hold = 1'b0;

    initial begin
        for (int b = 0; b < 16384; b++) begin
            mem[b] = {b[13:0], 2'd3, b[13:0], 2'd2, b[13:0], 2'd1, b[13:0], 2'd0};
        end
        mem[4] = 64'h4444_3333_2222_1111;
        bus.input_readyM = 1'b0;
        bus.doneM        = 1'b0;
        mem_drv   = 1'b0;
        mem_wdata = 64'h0;
        rd_cnt = 0;
        wr_cnt = 0;
        prev_addr = 16'h0;
        forever begin
            @(negedge clk);
            bus.input_readyM = 1'b0;
            bus.doneM        = 1'b0;
            mem_drv          = 1'b0;
            if (bus.readM && bus.writeM) overlap_err++;
            if (stray_req != stray_done) begin
                stray_done++;
                bus.input_readyM = 1'b1;
                bus.doneM        = 1'b1;
                mem_drv          = 1'b1;
                mem_wdata        = 64'hDEAD_BEEF_CAFE_F00D;
            end else if (!reset_n || resp_hold) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else if (bus.writeM) begin
                if (wr_cnt > 0 && bus.addressM != prev_addr) stab_err++;
                prev_addr = bus.addressM;
                wr_cnt++;
                if (wr_cnt == 2) begin
                    bus.doneM = 1'b1;
                    mem[bus.addressM[15:2]] = dataM_w;
                    last_wb_addr = bus.addressM;
                    last_wb_data = dataM_w;
                    n_wb_seen++;
                    wr_cnt = 0;
                end
            end else if (bus.readM) begin
                if (rd_cnt > 0 && bus.addressM != prev_addr) stab_err++;
                prev_addr = bus.addressM;
                rd_cnt++;
                if (rd_cnt == 2) begin
                    bus.input_readyM = 1'b1;
                    mem_drv          = 1'b1;
                    mem_wdata        = mem[bus.addressM[15:2]];
                    last_fill_addr   = bus.addressM;
                    n_fill++;
                    rd_cnt = 0;
                end
            end else begin
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_num_access"},    {48'h0, bus.num_access},    {48'h0, exp_access});
        check({tag, "_num_miss"},      {48'h0, bus.num_miss},      {48'h0, exp_miss});
        check({tag, "_num_writeback"}, {48'h0, bus.num_writeback}, {48'h0, exp_wb});
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   fills0, wbs0;
        bit   done;
        e.is_read = v.rd && !v.wr;
        e.rd      = v.exp_rd;
        e.lat     = v.lat;
        sb.push_back(e);
        fills0 = n_fill;
        wbs0   = n_wb_seen;
        done   = 1'b0;
        @(posedge clk); #1;
        bus.readC   = v.rd;
        bus.writeC  = v.wr;
        bus.address = v.addr;
        cpu_wdata   = v.wdata;
        cpu_drv     = v.wr;
        for (int cyc = 0; cyc < 16 && !done; cyc++) begin
            @(negedge clk);
            if (bus.readyC) begin
                done = 1'b1;
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.lat));
                if (e.is_read) check("rdata", {48'h0, data_w}, {48'h0, e.rd});
            end
        end
        if (!done) begin
            void'(sb.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL timeout: readyC never rose for address %h", v.addr);
        end
        @(posedge clk); #1;
        bus.readC  = 1'b0;
        bus.writeC = 1'b0;
        cpu_drv    = 1'b0;
        exp_access = exp_access + 16'd1;
        if (v.lat > 0) exp_miss = exp_miss + 16'd1;
        if (v.lat == 5) exp_wb = exp_wb + 16'd1;
        @(negedge clk);
        check_counters("req");
        check("refills", 64'(n_fill - fills0), (v.lat > 0) ? 64'd1 : 64'd0);
        check("writebacks", 64'(n_wb_seen - wbs0), (v.lat == 5) ? 64'd1 : 64'd0);
        if (v.lat > 0) check("fill_addr", {48'h0, last_fill_addr}, {48'h0, v.addr[15:2], 2'b00});
        if (v.lat == 5) check("wb_addr", {48'h0, last_wb_addr}, {48'h0, v.wb_addr});
        if (v.chk_wbd) check("wb_data", last_wb_data, v.wb_data);
    endtask

    initial begin
        bit seen;
        //            rd    wr    addr      wdata     exp_rd    lat wb_addr  chkd  wb_data
        vecs.push_back('{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h4444, 3, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1111, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 1'b1, 16'h0011, 16'h00AB, 16'h0000, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h00AB, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0050, 5, 16'h0010, 1'b1, 64'h4444_3333_00AB_1111});
        vecs.push_back('{1'b0, 1'b1, 16'h0024, 16'hBEEF, 16'h0000, 3, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0024, 16'h0000, 16'hBEEF, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0027, 16'h0000, 16'h0027, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0064, 16'h0000, 16'h0064, 5, 16'h0024, 1'b1, 64'h0027_0026_0025_BEEF});
        vecs.push_back('{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h00AB, 3, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b1, 16'h0013, 16'h5555, 16'h0000, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h5555, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 3, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFC, 16'h0000, 16'hFFFC, 0, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b0, 1'b1, 16'h003C, 16'h1234, 16'h0000, 3, 16'h0000, 1'b0, 64'h0});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'hFFFE, 5, 16'h003C, 1'b1, 64'h003F_003E_003D_1234});
        vecs.push_back('{1'b1, 1'b0, 16'h0024, 16'h0000, 16'hBEEF, 3, 16'h0000, 1'b0, 64'h0});

        reset_n     = 1'b0;
        bus.readC   = 1'b0;
        bus.writeC  = 1'b0;
        bus.address = 16'h0000;
        cpu_drv     = 1'b0;
        cpu_wdata   = 16'h0000;
        exp_access  = 16'h0;
        exp_miss    = 16'h0;
        exp_wb      = 16'h0;
        #1;
        check("reset_readM",    {63'h0, bus.readM},  64'h0);
        check("reset_writeM",   {63'h0, bus.writeM}, 64'h0);
        check("reset_readyC",   {63'h0, bus.readyC}, 64'h0);
        check("reset_addressM", {48'h0, bus.addressM}, 64'h0);
        check_counters("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // stray pulses in IDLE must not touch the cached line
        stray_req++;
        repeat (3) @(negedge clk);
        run_vec('{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h5555, 0, 16'h0000, 1'b0, 64'h0});

        // reset in the middle of a refill abandons it
        resp_hold = 1'b1;
        seen = 1'b0;
        @(posedge clk); #1;
        bus.readC   = 1'b1;
        bus.address = 16'h0084;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.readM) seen = 1'b1;
        end
        check("midalloc_readM_seen", {63'h0, seen}, 64'h1);
        #2;
        reset_n   = 1'b0;
        bus.readC = 1'b0;
        #1;
        exp_access = 16'h0;
        exp_miss   = 16'h0;
        exp_wb     = 16'h0;
        check("midalloc_readM_drop", {63'h0, bus.readM}, 64'h0);
        check("midalloc_addressM",   {48'h0, bus.addressM}, 64'h0);
        check_counters("midalloc");
        repeat (2) @(negedge clk);
        #2;
        reset_n   = 1'b1;
        resp_hold = 1'b0;
        stray_req++;
        repeat (3) @(negedge clk);
        check("late_pulse_readM", {63'h0, bus.readM}, 64'h0);
        check_counters("late_pulse");
        // the line filled before reset must miss again: valid bits were cleared
        run_vec('{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h4444, 3, 16'h0000, 1'b0, 64'h0});

        check("read_write_overlap", 64'(overlap_err), 64'h0);
        check("addressM_stable",    64'(stab_err),    64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
